// File: rtl/aggr_scheduler_if.sv
// ----------------------------------------------------------------------------
// aggr_scheduler_if
// Groups the descriptor, alpha-FIFO, WH BRAM and accumulator-side signals of
// the aggregation scheduler.
//   master : scheduler side (drives desc_rdy_o, alpha_ff_rd_vld_o,
//            wh_bram_addrb_o, acc_vld_o, acc_first_o, acc_last_o)
//   slave  : environment side (drives desc_vld_i, desc_num_node_i,
//            alpha_ff_empty_i, acc_rdy_i)
// ----------------------------------------------------------------------------
interface aggr_scheduler_if #(
   parameter int WH_ADDR_W      = 14,
   parameter int NUM_NODE_WIDTH = 8
);
   logic                      desc_vld_i;
   logic                      desc_rdy_o;
   logic [NUM_NODE_WIDTH-1:0] desc_num_node_i;
   logic                      alpha_ff_empty_i;
   logic                      alpha_ff_rd_vld_o;
   logic [WH_ADDR_W-1:0]      wh_bram_addrb_o;
   logic                      acc_vld_o;
   logic                      acc_first_o;
   logic                      acc_last_o;
   logic                      acc_rdy_i;

   modport master (
      input  desc_vld_i, desc_num_node_i, alpha_ff_empty_i, acc_rdy_i,
      output desc_rdy_o, alpha_ff_rd_vld_o, wh_bram_addrb_o,
             acc_vld_o, acc_first_o, acc_last_o
   );

   modport slave (
      output desc_vld_i, desc_num_node_i, alpha_ff_empty_i, acc_rdy_i,
      input  desc_rdy_o, alpha_ff_rd_vld_o, wh_bram_addrb_o,
             acc_vld_o, acc_first_o, acc_last_o
   );
endinterface

// File: rtl/aggr_scheduler.sv
// ----------------------------------------------------------------------------
// aggr_scheduler
// Walks one layer pass: fetches a descriptor per subgraph, then issues one
// node per cycle (alpha FIFO pop + WH BRAM read) whenever the alpha FIFO has
// data and the accumulator can accept. The BRAM address runs linearly across
// the whole pass. Accumulator tags are presented one cycle after issue so
// they line up with the BRAM read data.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           one-cycle pass start (ignored while busy_o)
//   sg_total_i        subgraph count, sampled on an accepted start
//   bus (master)      descriptor / alpha FIFO / WH BRAM / accumulator signals
//   busy_o            high outside IDLE
//   done_o            one-cycle pulse at the end of the pass
//   perf_stall_cnt_o  RUN cycles without an issue
//
// Build option
//   AGGR_SCHED_PERF_EN : when defined, perf_stall_cnt_o is a saturating
//                        stall counter; otherwise it is tied to zero.
// ----------------------------------------------------------------------------
module aggr_scheduler #(
   parameter int WH_ADDR_W      = 14,
   parameter int NUM_NODE_WIDTH = 8,
   parameter int SG_CNT_W       = 12
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic [SG_CNT_W-1:0] sg_total_i,
   aggr_scheduler_if.master    bus,
   output logic                busy_o,
   output logic                done_o,
   output logic [31:0]         perf_stall_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [WH_ADDR_W-1:0]      ADDR_ONE = 1;
   localparam logic [NUM_NODE_WIDTH-1:0] NODE_ONE = 1;
   localparam logic [SG_CNT_W-1:0]       SG_ONE   = 1;

   state_t                    state_reg, state_next;
   logic [WH_ADDR_W-1:0]      addr_reg;
   logic [NUM_NODE_WIDTH-1:0] node_cnt_reg;
   logic [NUM_NODE_WIDTH-1:0] num_node_reg;
   logic [SG_CNT_W-1:0]       sg_left_reg;   // subgraphs not yet completed
   logic                      acc_vld_reg, acc_first_reg, acc_last_reg;

   logic issue, desc_rdy, busy, done;
   logic start_accept, desc_accept;
   logic sg_final, node_last;

   // The subgraph in flight is the last one of the pass.
   assign sg_final  = (sg_left_reg == SG_ONE);
   // num_node_reg is never zero in RUN, so the subtraction cannot underflow there.
   assign node_last = (node_cnt_reg == (num_node_reg - NODE_ONE));

   assign start_accept = start_i && (state_reg == S_IDLE);
   assign desc_accept  = desc_rdy && bus.desc_vld_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      issue      = 1'b0;
      desc_rdy   = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state_reg)
         S_IDLE: begin
            busy = 1'b0;
            if (start_i) begin
               state_next = (sg_total_i == '0) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            desc_rdy = 1'b1;
            if (bus.desc_vld_i) begin
               if (bus.desc_num_node_i != '0) begin
                  state_next = S_RUN;
               end else if (sg_final) begin
                  // An empty final subgraph ends the pass right here.
                  state_next = S_DONE;
               end
            end
         end
         S_RUN: begin
            issue = !bus.alpha_ff_empty_i && bus.acc_rdy_i;
            if (issue && node_last) begin
               state_next = sg_final ? S_DONE : S_LOAD;
            end
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_reg      <= '0;
         node_cnt_reg  <= '0;
         num_node_reg  <= '0;
         sg_left_reg   <= '0;
         acc_vld_reg   <= 1'b0;
         acc_first_reg <= 1'b0;
         acc_last_reg  <= 1'b0;
      end else begin
         // Tags follow the issue by one cycle to match the BRAM read latency.
         acc_vld_reg   <= issue;
         acc_first_reg <= issue && (node_cnt_reg == '0);
         acc_last_reg  <= issue && node_last;

         if (start_accept) begin
            addr_reg     <= '0;
            node_cnt_reg <= '0;
            sg_left_reg  <= sg_total_i;
         end else if (desc_accept) begin
            num_node_reg <= bus.desc_num_node_i;
            node_cnt_reg <= '0;
            if (bus.desc_num_node_i == '0) begin
               sg_left_reg <= sg_left_reg - SG_ONE;
            end
         end else if (issue) begin
            addr_reg <= addr_reg + ADDR_ONE;
            if (node_last) begin
               node_cnt_reg <= '0;
               sg_left_reg  <= sg_left_reg - SG_ONE;
            end else begin
               node_cnt_reg <= node_cnt_reg + NODE_ONE;
            end
         end
      end
   end

`ifdef AGGR_SCHED_PERF_EN
   logic [31:0] stall_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_reg <= '0;
      end else if (start_accept) begin
         stall_cnt_reg <= '0;
      end else if ((state_reg == S_RUN) && !issue && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
         stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
   end

   assign perf_stall_cnt_o = stall_cnt_reg;
`else
   assign perf_stall_cnt_o = 32'd0;
`endif

   assign bus.desc_rdy_o        = desc_rdy;
   assign bus.alpha_ff_rd_vld_o = issue;
   assign bus.wh_bram_addrb_o   = addr_reg;
   assign bus.acc_vld_o         = acc_vld_reg;
   assign bus.acc_first_o       = acc_first_reg;
   assign bus.acc_last_o        = acc_last_reg;
   assign busy_o                = busy;
   assign done_o                = done;

endmodule

// File: tb/tb_aggr_scheduler.sv
// ----------------------------------------------------------------------------
// tb_aggr_scheduler
// Directed and randomized passes against a transaction-level model: the model
// tracks accepted descriptors, nodes still owed for the current subgraph and
// the running issue count, and derives every expected output from those.
// ----------------------------------------------------------------------------
module tb_aggr_scheduler;

   logic        clk;
   logic        rst_n;
   logic        start_i;
   logic [11:0] sg_total_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] perf_stall_cnt_o;

   aggr_scheduler_if #(.WH_ADDR_W(14), .NUM_NODE_WIDTH(8)) bus ();

   aggr_scheduler #(
      .WH_ADDR_W      (14),
      .NUM_NODE_WIDTH (8),
      .SG_CNT_W       (12)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start_i          (start_i),
      .sg_total_i       (sg_total_i),
      .bus              (bus),
      .busy_o           (busy_o),
      .done_o           (done_o),
      .perf_stall_cnt_o (perf_stall_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int done_pulses = 0;
   int last_done_cyc = 0;

   // Transaction-level model state
   int     desc_q[$];
   bit     m_active;
   int     m_addr, m_total, m_consumed, m_out, m_idx, m_n;
   bit     m_done_due, m_acc_vld, m_acc_first, m_acc_last;
   longint m_stall;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_addr = 0; m_total = 0; m_consumed = 0;
      m_out = 0; m_idx = 0; m_n = 0; m_done_due = 0;
      m_acc_vld = 0; m_acc_first = 0; m_acc_last = 0; m_stall = 0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_addr"},   64'(bus.wh_bram_addrb_o), 64'd0);
      chk({tag, "_accvld"}, 64'(bus.acc_vld_o), 64'd0);
      chk({tag, "_first"},  64'(bus.acc_first_o), 64'd0);
      chk({tag, "_last"},   64'(bus.acc_last_o), 64'd0);
      chk({tag, "_busy"},   64'(busy_o), 64'd0);
      chk({tag, "_done"},   64'(done_o), 64'd0);
      chk({tag, "_drdy"},   64'(bus.desc_rdy_o), 64'd0);
      chk({tag, "_pop"},    64'(bus.alpha_ff_rd_vld_o), 64'd0);
      chk({tag, "_perf"},   64'(perf_stall_cnt_o), 64'd0);
   endtask

   // One clock cycle: check registered outputs, drive inputs, check
   // combinational outputs, then advance the model across the clock edge.
   task automatic tick(input bit st, input int tot, input bit emp, input bit rdy, input bit dv);
      bit exp_drdy, exp_issue, start_acc, was_done;
      int n;
      @(negedge clk);
      chk("addr",      64'(bus.wh_bram_addrb_o), 64'(m_addr));
      chk("acc_vld",   64'(bus.acc_vld_o), 64'(m_acc_vld));
      chk("acc_first", 64'(bus.acc_first_o), 64'(m_acc_first));
      chk("acc_last",  64'(bus.acc_last_o), 64'(m_acc_last));
      chk("busy",      64'(busy_o), 64'(m_active));
      chk("done",      64'(done_o), 64'(m_done_due));
`ifdef AGGR_SCHED_PERF_EN
      chk("perf",      64'(perf_stall_cnt_o), 64'(m_stall));
`else
      chk("perf",      64'(perf_stall_cnt_o), 64'd0);
`endif
      if (done_o === 1'b1) begin
         done_pulses++;
         last_done_cyc = cyc;
      end

      start_i              = st;
      sg_total_i           = 12'(tot);
      bus.alpha_ff_empty_i = emp;
      bus.acc_rdy_i        = rdy;
      bus.desc_vld_i       = dv && (desc_q.size() > 0);
      bus.desc_num_node_i  = (desc_q.size() > 0) ? 8'(desc_q[0]) : 8'd0;
      #1;
      exp_drdy  = m_active && (m_out == 0) && (m_consumed < m_total);
      exp_issue = (m_out > 0) && !emp && rdy;
      chk("desc_rdy", 64'(bus.desc_rdy_o), 64'(exp_drdy));
      chk("pop",      64'(bus.alpha_ff_rd_vld_o), 64'(exp_issue));

      start_acc  = st && !m_active;
      was_done   = m_done_due;
      m_done_due = 0;
      m_acc_vld   = exp_issue;
      m_acc_first = exp_issue && (m_idx == 0);
      m_acc_last  = exp_issue && (m_idx == m_n - 1);
      if ((m_out > 0) && !exp_issue && (m_stall < 64'hFFFF_FFFF)) m_stall++;
      if (exp_issue) begin
         m_addr++;
         m_idx++;
         m_out--;
         if ((m_out == 0) && (m_consumed == m_total)) m_done_due = 1;
      end
      if (exp_drdy && bus.desc_vld_i) begin
         n = desc_q.pop_front();
         m_consumed++;
         if (n == 0) begin
            if (m_consumed == m_total) m_done_due = 1;
         end else begin
            m_out = n; m_n = n; m_idx = 0;
         end
      end
      if (was_done) m_active = 0;
      if (start_acc) begin
         m_active = 1; m_addr = 0; m_total = tot; m_consumed = 0;
         m_out = 0; m_stall = 0;
         if (tot == 0) m_done_due = 1;
      end
      cyc++;
   endtask

   task automatic begin_pass(input int tot);
      tick(1, tot, 0, 1, 1);
   endtask

   task automatic run_directed(input string tag, input int limit);
      int g = 0;
      while (m_active && g < limit) begin
         tick(0, 0, 0, 1, 1);
         g++;
      end
      chk({tag, "_timeout"}, 64'(m_active), 64'd0);
   endtask

   task automatic run_random(input int limit);
      int g = 0;
      while (m_active && g < limit) begin
         tick($urandom_range(0, 9) == 0, int'($urandom_range(0, 3)),
              $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0,
              $urandom_range(0, 3) != 0);
         g++;
      end
      chk("rand_timeout", 64'(m_active), 64'd0);
   endtask

   initial begin
      int start_cyc, pulses_before, tot, g;

      rst_n = 1'b0;
      start_i = 1'b0;
      sg_total_i = '0;
      bus.desc_vld_i = 1'b0;
      bus.desc_num_node_i = '0;
      bus.alpha_ff_empty_i = 1'b1;
      bus.acc_rdy_i = 1'b0;
      model_reset();

      // Reset state, then no pop in the first cycle after release
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      bus.alpha_ff_empty_i = 1'b0;
      bus.acc_rdy_i = 1'b1;
      rst_n = 1'b1;
      #1;
      chk("post_reset_pop", 64'(bus.alpha_ff_rd_vld_o), 64'd0);

      // Two subgraphs {3,2}, no stalls
      desc_q = '{3, 2};
      start_cyc = cyc;
      begin_pass(2);
      run_directed("two_sg", 50);
      chk("two_sg_latency", 64'(last_done_cyc - start_cyc), 64'd8);
      chk("two_sg_end_addr", 64'(bus.wh_bram_addrb_o), 64'd5);

      // Alpha FIFO empty for 2 cycles after node 1
      desc_q = '{4};
      begin_pass(1);
      tick(0, 0, 0, 1, 1);
      tick(0, 0, 0, 1, 1);
      tick(0, 0, 0, 1, 1);
      tick(0, 0, 1, 1, 1);
      tick(0, 0, 1, 1, 1);
      run_directed("empty_gap", 50);
`ifdef AGGR_SCHED_PERF_EN
      chk("empty_gap_stall", 64'(perf_stall_cnt_o), 64'd2);
`else
      chk("empty_gap_stall", 64'(perf_stall_cnt_o), 64'd0);
`endif

      // {2,0,1}: empty middle subgraph
      desc_q = '{2, 0, 1};
      pulses_before = done_pulses;
      start_cyc = cyc;
      begin_pass(3);
      run_directed("zero_sg", 50);
      chk("zero_sg_latency", 64'(last_done_cyc - start_cyc), 64'd7);
      chk("zero_sg_pulses", 64'(done_pulses - pulses_before), 64'd1);
      chk("zero_sg_end_addr", 64'(bus.wh_bram_addrb_o), 64'd3);

      // Empty pass
      desc_q.delete();
      start_cyc = cyc;
      begin_pass(0);
      run_directed("empty_pass", 10);
      chk("empty_pass_latency", 64'(last_done_cyc - start_cyc), 64'd1);

      // Reset in the middle of RUN at address 5
      desc_q = '{8};
      begin_pass(1);
      g = 0;
      while (m_addr != 5 && g < 50) begin
         tick(0, 0, 0, 1, 1);
         g++;
      end
      @(negedge clk);
      chk("midrun_addr5", 64'(bus.wh_bram_addrb_o), 64'd5);
      rst_n = 1'b0;
      #1;
      check_all_zero("midrun_rst");
      @(negedge clk);
      check_all_zero("midrun_rst_hold");
      rst_n = 1'b1;
      model_reset();
      desc_q.delete();
      #1;
      chk("midrun_release_pop", 64'(bus.alpha_ff_rd_vld_o), 64'd0);
      tick(0, 0, 0, 1, 1);
      desc_q = '{3};
      begin_pass(1);
      run_directed("after_rst", 50);
      chk("after_rst_end_addr", 64'(bus.wh_bram_addrb_o), 64'd3);

      // Accumulator backpressure for 3 cycles plus starts while busy
      desc_q = '{4};
      begin_pass(1);
      tick(0, 0, 0, 1, 1);
      tick(0, 0, 0, 1, 1);
      tick(1, 2, 0, 0, 1);
      tick(0, 0, 0, 0, 1);
      tick(1, 3, 0, 0, 1);
      run_directed("backpressure", 50);
      chk("backpressure_end_addr", 64'(bus.wh_bram_addrb_o), 64'd4);

      // Randomized passes
      for (int p = 0; p < 25; p++) begin
         tot = int'($urandom_range(0, 3));
         desc_q.delete();
         for (int s = 0; s < tot; s++) desc_q.push_back(int'($urandom_range(0, 5)));
         begin_pass(tot);
         run_random(400);
         for (int k = 0; k < int'($urandom_range(0, 2)); k++)
            tick(0, 0, $urandom_range(0, 1) == 1, 1, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/aggr_scheduler.md
AGGR_SCHEDULER -- requirements
Module: aggr_scheduler

Interface
REQ-001 SHALL have parameter WH_ADDR_W, default 14, meaning the WH BRAM address width.
REQ-002 SHALL have parameter NUM_NODE_WIDTH, default 8, meaning the per-subgraph node-count width.
REQ-003 SHALL have parameter SG_CNT_W, default 12, meaning the subgraph-counter width.
REQ-004 SHALL have port clk, input, 1, the clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-005 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-006 SHALL have port start_i, input, 1, a single-cycle pulse that starts a layer pass.
REQ-007 SHALL have port sg_total_i, input, SG_CNT_W, the number of subgraphs in the pass, sampled on an accepted start.
REQ-008 SHALL have ports desc_vld_i (input, 1) / desc_rdy_o (output, 1), the descriptor handshake.
REQ-009 SHALL have port desc_num_node_i, input, NUM_NODE_WIDTH, the node count of the next subgraph.
REQ-010 SHALL have ports alpha_ff_empty_i (input, 1) / alpha_ff_rd_vld_o (output, 1), the alpha FIFO status and pop.
REQ-011 SHALL have port wh_bram_addrb_o, output, WH_ADDR_W, the WH BRAM read address (1-cycle read latency).
REQ-012 SHALL have ports acc_vld_o, acc_first_o and acc_last_o (output, 1 each) and acc_rdy_i (input, 1), the accumulator-side tags and backpressure.
REQ-013 SHALL have ports busy_o (output, 1), done_o (output, 1) and perf_stall_cnt_o (output, 32).

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, RUN, DONE.
- IDLE->LOAD: on start_i with sg_total_i!=0.
- IDLE->DONE: on start_i with sg_total_i==0.
- LOAD->RUN: on desc handshake with num_node!=0.
- RUN->LOAD: on last node issued while subgraphs remain.
- RUN->DONE: on last node issued of the final subgraph.
- DONE->IDLE: unconditionally after 1 cycle.
REQ-015 SHALL assert desc_rdy_o only in LOAD, and accept a descriptor when desc_vld_i&&desc_rdy_o.
REQ-016 SHALL treat an accepted descriptor with num_node==0 as a completed subgraph: issue nothing, stay in LOAD or go to DONE if it was the final subgraph.
REQ-017 SHALL issue one node in RUN iff !alpha_ff_empty_i&&acc_rdy_i, with alpha_ff_rd_vld_o driven combinationally high in that cycle and low otherwise.
REQ-018 SHALL reset the registered wh_bram_addrb_o to 0 on an accepted start and increment it by 1 after each issue, continuing across subgraph boundaries without wrapping.
REQ-019 SHALL assert acc_vld_o exactly 1 cycle after each issue, aligned with the BRAM data.
REQ-020 SHALL assert acc_first_o with the first node of a subgraph and acc_last_o with node num_node-1; both SHALL be set for num_node==1.
REQ-021 SHALL hold busy_o high in all states other than IDLE.
REQ-022 SHALL pulse done_o for exactly 1 cycle in DONE, which occurs 1 cycle after the final issue so the last acc_vld_o coincides with done_o.
REQ-023 SHALL ignore start_i while busy_o is high.
REQ-024 SHALL make acc_rdy_i low stall issue only; already-issued acc_vld_o SHALL still be presented.

Reset
REQ-025 SHALL drive, on rst_n low at any time including mid-pass: state=IDLE; wh_bram_addrb_o, node and subgraph counters=0; acc_vld_o/first/last=0; busy_o=0; done_o=0; desc_rdy_o=0; perf_stall_cnt_o=0.
REQ-026 SHALL prevent any pop or issue in the first cycle after reset release.

Configuration
REQ-027 SHALL, with macro AGGR_SCHED_PERF_EN defined, count in perf_stall_cnt_o (saturating at 2^32-1) the RUN cycles without an issue, clearing it on an accepted start.
REQ-028 SHALL, without AGGR_SCHED_PERF_EN, tie perf_stall_cnt_o to 0 and synthesize no counter logic.

Verification
REQ-029 SHALL cover: sg_total=2, num_node {3,2}, FIFO never empty, acc_rdy=1 -> addrs 0..4 on consecutive cycles, first at nodes 0 and 3, last at nodes 2 and 4, done_o 1 cycle after addr 4.
REQ-030 SHALL cover: sg_total=1, num_node=4, alpha empty for 2 cycles after node 1 -> no pop while empty, addr holds at 2, stall count=2 with macro defined.
REQ-031 SHALL cover: sg_total=3, num_node {2,0,1} -> middle subgraph skipped, addrs 0,1,2, last tag on addrs 1 and 2, single done pulse.
REQ-032 SHALL cover: sg_total=0 -> done_o 1 cycle after start, no desc_rdy_o, no pops.
REQ-033 SHALL cover: rst_n asserted mid-RUN at addr 5, then a new start -> all outputs 0 during reset, and the new pass begins at addr 0.
REQ-034 SHALL cover: acc_rdy_i low for 3 cycles plus start_i pulsed while busy -> no issue while acc_rdy_i is low, second start ignored, pass completes normally.
